// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC
// and the instruction words the fetch path and decoder agree on.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] HLT_WORD         = 16'hFE00;
  localparam logic [15:0] ZERO_INSTR       = 16'h0000;

  // Sequential PC step; wraps naturally at 2^16.
  function automatic logic [15:0] pc_step(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Memory read port of the fetch unit: a held request with a one-cycle ack.
interface ifetch_unit_if;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, mem_addr, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ack);

endinterface

// File: rtl/ifetch_unit_fetch_watchdog.sv
// Bus watchdog: counts cycles a fetch has waited for its ack and flags the
// cycle in which the wait budget is exhausted.
module fetch_watchdog
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/ifetch_unit.sv
// Program counter, fetch FSM and instruction register feeding the microcoded
// decoder, plus the sticky fault and latched interrupt flags it samples.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned TO_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IR_LOAD,
  input  logic                 INCR_PC,
  input  logic                 PC_LOAD,
  input  logic [15:0]          pc_in,
  ifetch_unit_if.master        mem,
  output logic [15:0]          instr,
  output logic [15:0]          pc,
  output logic                 busy,
  output logic                 fault_r,
  input  logic                 fault_clr,
  input  logic                 irq,
  input  logic                 irq_ack,
  output logic                 irq_r
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  addr_q, addr_d;
  logic         fault_q, fault_d;
  logic         irq_q, irq_d;
  logic         fault_set;
  logic         wd_clr, wd_en, wd_tc;

  fetch_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    fault_set = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (IR_LOAD) begin
          if (pc_q[0]) begin
            state_d   = ST_FAULT;
            instr_d   = ZERO_INSTR;
            fault_set = 1'b1;
          end else begin
            state_d = ST_REQ;
            addr_d  = pc_q;
            wd_clr  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // An ack in the last permitted cycle still completes the fetch.
        if (mem.mem_ack) begin
          state_d = ST_IDLE;
          instr_d = mem.mem_rdata;
        end else if (wd_tc) begin
          state_d   = ST_FAULT;
          instr_d   = ZERO_INSTR;
          fault_set = 1'b1;
        end else begin
          wd_en = 1'b1;
        end
      end
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (PC_LOAD) begin
      pc_d = pc_in;
    end else if (INCR_PC) begin
      pc_d = pc_step(pc_q);
    end
    fault_d = fault_set | (fault_q & ~fault_clr);
    irq_d   = irq | (irq_q & ~irq_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= ZERO_INSTR;
      addr_q  <= '0;
      fault_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
      irq_q   <= irq_d;
    end
  end

  assign mem.mem_req  = (state_q == ST_REQ);
  assign mem.mem_addr = addr_q;
  assign instr        = instr_q;
  assign pc           = pc_q;
  assign busy         = (state_q != ST_IDLE);
  assign fault_r      = fault_q;
  assign irq_r        = irq_q;

endmodule
